// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: MUL_CYCLES-cycle multiply, 32-step restoring divide + sign fix, MTHI/MTLO.
// Latency MUL_CYCLES / 33 / 1 edges; start is ignored outside IDLE and busy stalls the execute stage.
module muldiv_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [4:0] MUL_INIT = 5'(MUL_CYCLES - 1);

    state_t      state, state_d;
    logic [4:0]  cnt, cnt_d;
    logic        busy_d, done_d;
    logic [31:0] hi_d, lo_d;
    logic [31:0] op_a, op_a_d, op_b, op_b_d;
    logic [63:0] rq, rq_d;
    logic [2:0]  op_r, op_r_d;
    logic        mul_sgn, mul_sgn_d;
    logic        sign_q, sign_q_d, sign_r, sign_r_d;
    logic        dz, dz_d;

    logic [63:0] mul_a, mul_b, prod;
    logic [32:0] trial;
    logic [63:0] rq_step;
    logic        sdiv;
    logic [31:0] abs_a, abs_b, quot, rem;

    // Sign-extend to 64 bits so a plain unsigned multiply yields the right low 64 bits.
    assign mul_a = {{32{mul_sgn & op_a[31]}}, op_a};
    assign mul_b = {{32{mul_sgn & op_b[31]}}, op_b};
    assign prod  = mul_a * mul_b;

    // Restoring step: shifted remainder is 33 bits wide, a borrow means "restore".
    assign trial   = rq[63:31] - {1'b0, op_b};
    assign rq_step = trial[32] ? {rq[62:0], 1'b0} : {trial[31:0], rq[30:0], 1'b1};

    assign sdiv  = ~op[0];
    assign abs_a = (sdiv & src_a[31]) ? -src_a : src_a;
    assign abs_b = (sdiv & src_b[31]) ? -src_b : src_b;
    assign quot  = sign_q ? -rq[31:0]  : rq[31:0];
    assign rem   = sign_r ? -rq[63:32] : rq[63:32];

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        done_d    = 1'b0;
        hi_d      = hi;
        lo_d      = lo;
        op_a_d    = op_a;
        op_b_d    = op_b;
        rq_d      = rq;
        op_r_d    = op_r;
        mul_sgn_d = mul_sgn;
        sign_q_d  = sign_q;
        sign_r_d  = sign_r;
        dz_d      = dz;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    op_r_d = op;
                    op_a_d = src_a;
                    op_b_d = src_b;
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            mul_sgn_d = ~op[0];
                            cnt_d     = MUL_INIT;
                            state_d   = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_b_d   = abs_b;
                            rq_d     = {32'd0, abs_a};
                            sign_q_d = sdiv & (src_a[31] ^ src_b[31]);
                            sign_r_d = sdiv & src_a[31];
                            dz_d     = (src_b == 32'd0);
                            cnt_d    = 5'd31;
                            state_d  = (src_b == 32'd0) ? FIX : DIV;
                        end
                        default: state_d = FIX;
                    endcase
                end
            end
            MUL: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt == 5'd0) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 5'd1;
                end
            end
            DIV: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rq_d = rq_step;
                    if (cnt == 5'd0) state_d = FIX;
                    else             cnt_d   = cnt - 5'd1;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    case (op_r)
                        OP_DIV, OP_DIVU: begin
                            done_d = 1'b1;
                            if (!dz) begin
                                lo_d = quot;
                                hi_d = rem;
                            end
                        end
                        OP_MTHI: hi_d = op_a;
                        OP_MTLO: lo_d = op_a;
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
        // busy covers every edge that stays in flight, never the accept edge itself.
        busy_d = (state != IDLE) && (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            op_a    <= 32'd0;
            op_b    <= 32'd0;
            rq      <= 64'd0;
            op_r    <= 3'd0;
            mul_sgn <= 1'b0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dz      <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            hi      <= hi_d;
            lo      <= lo_d;
            op_a    <= op_a_d;
            op_b    <= op_b_d;
            rq      <= rq_d;
            op_r    <= op_r_d;
            mul_sgn <= mul_sgn_d;
            sign_q  <= sign_q_d;
            sign_r  <= sign_r_d;
            dz      <= dz_d;
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed vector table, flush/reset corner sequences, randomized ops vs arithmetic model.
module tb_muldiv_ctrl;
    localparam int MC = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_CYCLES(MC)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;
    vec_t tbl [16];

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    // Architectural effect of one request, from plain integer arithmetic.
    task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin q = sa * sb; hi_m = q[63:32]; lo_m = q[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
            3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
            3'd3: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
            3'd4: hi_m = a;
            3'd5: lo_m = a;
            default: ;
        endcase
    endtask

    // Issue one request right after an edge; check busy/done on every edge until it completes.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input string nm);
        int len;
        bit has_done;
        has_done = (o <= 3'd3);
        if (o <= 3'd1)                 len = MC;
        else if (o <= 3'd3 && b != 0)  len = 33;
        else                           len = 1;
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk1($sformatf("%s busy@0", nm), busy, 1'b0);
        chk1($sformatf("%s done@0", nm), done, 1'b0);
        for (int e = 1; e <= len; e++) begin
            @(posedge clk); #1;
            chk1($sformatf("%s busy@%0d", nm, e), busy, e < len);
            chk1($sformatf("%s done@%0d", nm, e), done, has_done && (e == len));
        end
        chk32({nm, " hi"}, hi, eh);
        chk32({nm, " lo"}, lo, el);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        tbl[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
        tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
        tbl[4]  = '{3'd4, 32'h00001234, 32'h0,        32'h00001234, 32'd14};
        tbl[5]  = '{3'd5, 32'h00005678, 32'h0,        32'h00001234, 32'h00005678};
        tbl[6]  = '{3'd3, 32'd100,      32'd0,        32'h00001234, 32'h00005678};
        tbl[7]  = '{3'd4, 32'hAAAA5555, 32'h0,        32'hAAAA5555, 32'h00005678};
        tbl[8]  = '{3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAA5555, 32'h00005678};
        tbl[9]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[10] = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[11] = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        tbl[12] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        tbl[13] = '{3'd3, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000001};
        tbl[14] = '{3'd7, 32'h12345678, 32'h9ABCDEF0, 32'h7FFFFFFF, 32'h00000001};
        tbl[15] = '{3'd2, 32'h00000005, 32'h00000000, 32'h7FFFFFFF, 32'h00000001};

        repeat (2) @(posedge clk);
        #1;
        chk1("reset busy", busy, 1'b0);
        chk1("reset done", done, 1'b0);
        chk32("reset hi", hi, 32'd0);
        chk32("reset lo", lo, 32'd0);
        resetn = 1'b1;

        // Table entries run back-to-back: each start is raised in the previous done cycle.
        for (int i = 0; i < 16; i++) begin
            model_apply(tbl[i].o, tbl[i].a, tbl[i].b);
            do_op(tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, $sformatf("vec%0d", i));
        end

        // Flush mid-divide; a held start (MTHI) must be ignored while the divide is in flight.
        op = 3'd2; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        op = 3'd4; src_a = 32'hDEADBEEF;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            chk1($sformatf("flushdiv busy@%0d", e), busy, 1'b1);
        end
        start = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk1("flushdiv busy@11", busy, 1'b0);
        chk1("flushdiv done@11", done, 1'b0);
        dn = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        chk32("flushdiv done count", dn, 0);
        chk32("flushdiv hi", hi, hi_m);
        chk32("flushdiv lo", lo, lo_m);

        // Flush on the multiply completion edge wins over writeback and done.
        op = 3'd0; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e < MC; e++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk1("flushmul done", done, 1'b0);
        chk1("flushmul busy", busy, 1'b0);
        chk32("flushmul hi", hi, hi_m);
        chk32("flushmul lo", lo, lo_m);
        @(posedge clk); #1;
        chk1("flushmul done late", done, 1'b0);

        // Flush together with start in IDLE blocks the accept.
        op = 3'd5; src_a = 32'hCAFEF00D; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        chk32("flushstart lo", lo, lo_m);
        chk1("flushstart busy", busy, 1'b0);

        // Asynchronous reset in the middle of a divide.
        op = 3'd2; src_a = 32'd1000; src_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk1("rstdiv busy", busy, 1'b0);
        chk1("rstdiv done", done, 1'b0);
        chk32("rstdiv hi", hi, 32'd0);
        chk32("rstdiv lo", lo, 32'd0);
        hi_m = 32'd0;
        lo_m = 32'd0;
        @(posedge clk); #1;
        resetn = 1'b1;
        dn = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) dn++;
        end
        chk32("rstdiv quiet", dn, 0);

        // Randomized requests against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0)      rb = 32'd0;
            else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
            model_apply(ro, ra, rb);
            do_op(ro, ra, rb, hi_m, lo_m, $sformatf("rnd%0d op%0d", i, ro));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
